// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array/buffer geometry and the tile sequencer state set.
package tpu_pkg;

  localparam int unsigned TILE_DEF   = 4;
  localparam int unsigned DIM_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_RUN,
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile walker for the matmul sequencer: row-major tile order, per-tile dims and
// gbuff A/B/C base indices, all tracked with running adders/subtractors.
module tile_addr_gen
  import tpu_pkg::*;
#(
  parameter int unsigned TILE   = TILE_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  k,
  input  logic [DIM_W-1:0]  n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              last,
  output logic [DIM_W-1:0]  tile_m,
  output logic [DIM_W-1:0]  tile_k,
  output logic [DIM_W-1:0]  tile_n,
  output logic [ADDR_W-1:0] a_off,
  output logic [ADDR_W-1:0] b_off,
  output logic [ADDR_W-1:0] c_off
);

  localparam logic [DIM_W-1:0]  TILE_D = DIM_W'(TILE);
  localparam logic [ADDR_W-1:0] TILE_A = ADDR_W'(TILE);

  // rem_m/rem_n are M - mt*TILE and N - nt*TILE; they stand in for the mt/nt counters
  logic [DIM_W-1:0]  rem_m, rem_n, k_q, n_q;
  logic [ADDR_W-1:0] b_base_q, a_off_q, b_off_q, c_off_q;
  logic              row_last, col_last;

  assign row_last = (rem_m <= TILE_D);
  assign col_last = (rem_n <= TILE_D);
  assign last     = row_last & col_last;

  assign tile_m = row_last ? rem_m : TILE_D;
  assign tile_n = col_last ? rem_n : TILE_D;
  assign tile_k = k_q;
  assign a_off  = a_off_q;
  assign b_off  = b_off_q;
  assign c_off  = c_off_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_m    <= '0;
      rem_n    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      b_base_q <= '0;
      a_off_q  <= '0;
      b_off_q  <= '0;
      c_off_q  <= '0;
    end else if (init) begin
      rem_m    <= m;
      rem_n    <= n;
      k_q      <= k;
      n_q      <= n;
      b_base_q <= b_base;
      a_off_q  <= a_base;
      b_off_q  <= b_base;
      c_off_q  <= c_base;
    end else if (step && !last) begin
      // C tiles are packed in visit order, so the C index always advances by one tile
      c_off_q <= c_off_q + TILE_A;
      if (!col_last) begin
        rem_n   <= rem_n - TILE_D;
        b_off_q <= b_off_q + ADDR_W'(k_q);
      end else begin
        // Not last and columns exhausted implies rem_m > TILE, so no underflow
        rem_n   <= n_q;
        b_off_q <= b_base_q;
        rem_m   <= rem_m - TILE_D;
        a_off_q <= a_off_q + ADDR_W'(k_q);
      end
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Splits an M x K x N matmul into TILE x TILE output tiles and launches them one
// at a time on the systolic array, reporting completion to the CFU decoder.
module matmul_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned TILE   = TILE_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DIM_W-1:0]  job_m,
  input  logic [DIM_W-1:0]  job_k,
  input  logic [DIM_W-1:0]  job_n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  input  logic              abort,
  output logic              arr_enable,
  output logic [DIM_W-1:0]  arr_m,
  output logic [DIM_W-1:0]  arr_k,
  output logic [DIM_W-1:0]  arr_n,
  output logic [ADDR_W-1:0] arr_a_off,
  output logic [ADDR_W-1:0] arr_b_off,
  output logic [ADDR_W-1:0] arr_c_off,
  input  logic              arr_busy,
  output logic              done,
  output logic              err,
  output logic [DIM_W-1:0]  tiles_done
);

  seq_state_e       state_q, state_d;
  logic             arm_wait_q;
  logic             err_q;
  logic [DIM_W-1:0] tiles_done_q;
  logic             accept, tile_complete, zero_dim, gen_last;

  assign zero_dim = (job_m == '0) || (job_k == '0) || (job_n == '0);

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    tile_complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          accept  = 1'b1;
          state_d = zero_dim ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        // Busy is registered inside the array, so a low in the first cycle is not yet meaningful
        if (arr_busy)        state_d = S_RUN;
        else if (arm_wait_q) tile_complete = 1'b1;
      end
      S_RUN: begin
        if (!arr_busy) tile_complete = 1'b1;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tile_complete) state_d = gen_last ? S_FIN : S_ISSUE;
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      tile_complete = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      arm_wait_q   <= 1'b0;
      err_q        <= 1'b0;
      tiles_done_q <= '0;
    end else begin
      state_q    <= state_d;
      arm_wait_q <= (state_q == S_ARM);
      if (accept) begin
        err_q        <= zero_dim;
        tiles_done_q <= '0;
      end else if (tile_complete) begin
        tiles_done_q <= tiles_done_q + DIM_W'(1);
      end
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign arr_enable  = (state_q == S_ISSUE) && !abort;
  assign done        = (state_q == S_FIN) && !abort;
  assign err         = done && err_q;
  assign tiles_done  = tiles_done_q;

  tile_addr_gen #(
    .TILE   (TILE),
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (accept),
    .step    (tile_complete),
    .m       (job_m),
    .k       (job_k),
    .n       (job_n),
    .a_base  (a_base),
    .b_base  (b_base),
    .c_base  (c_base),
    .last    (gen_last),
    .tile_m  (arr_m),
    .tile_k  (arr_k),
    .tile_n  (arr_n),
    .a_off   (arr_a_off),
    .b_off   (arr_b_off),
    .c_off   (arr_c_off)
  );

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Self-checking bench for matmul_tile_sequencer: directed scenarios plus random jobs
// against a tile-list / cycle-count reference model and a simple systolic array model.
module tb_matmul_tile_sequencer;
  import tpu_pkg::*;

  localparam int TILE   = 4;
  localparam int DIM_W  = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start_valid, start_ready;
  logic [DIM_W-1:0]  job_m, job_k, job_n;
  logic [ADDR_W-1:0] a_base, b_base, c_base;
  logic              abort;
  logic              arr_enable;
  logic [DIM_W-1:0]  arr_m, arr_k, arr_n;
  logic [ADDR_W-1:0] arr_a_off, arr_b_off, arr_c_off;
  logic              arr_busy;
  logic              done, err;
  logic [DIM_W-1:0]  tiles_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int m, k, n, a, b, c;
  } job_t;

  typedef struct {
    int m, n, k, a, b, c;
  } tile_t;

  tile_t exp_q[$];

  // array model: busy rises rise_cfg cycles after the launch edge and lasts len_cfg cycles
  int rise_cfg = 0;
  int len_cfg  = 1;
  int since;

  always #5 clk = ~clk;

  matmul_tile_sequencer #(
    .TILE   (TILE),
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .job_m       (job_m),
    .job_k       (job_k),
    .job_n       (job_n),
    .a_base      (a_base),
    .b_base      (b_base),
    .c_base      (c_base),
    .abort       (abort),
    .arr_enable  (arr_enable),
    .arr_m       (arr_m),
    .arr_k       (arr_k),
    .arr_n       (arr_n),
    .arr_a_off   (arr_a_off),
    .arr_b_off   (arr_b_off),
    .arr_c_off   (arr_c_off),
    .arr_busy    (arr_busy),
    .done        (done),
    .err         (err),
    .tiles_done  (tiles_done)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       since <= -1;
    else if (arr_enable)                since <= 0;
    else if (since >= 0 && since < 10000) since <= since + 1;
  end

  always_comb begin
    arr_busy = 1'b0;
    if (since >= rise_cfg && since < rise_cfg + len_cfg) arr_busy = 1'b1;
  end

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int tile_cycles(input int rise, input int len);
    return (len == 0) ? 3 : 2 + rise + len;
  endfunction

  task automatic build_expected(input job_t j);
    int mt_cnt, nt_cnt;
    tile_t t;
    exp_q.delete();
    if (j.m == 0 || j.k == 0 || j.n == 0) return;
    mt_cnt = (j.m + TILE - 1) / TILE;
    nt_cnt = (j.n + TILE - 1) / TILE;
    for (int mt = 0; mt < mt_cnt; mt++) begin
      for (int nt = 0; nt < nt_cnt; nt++) begin
        t.m = (j.m - mt * TILE < TILE) ? j.m - mt * TILE : TILE;
        t.n = (j.n - nt * TILE < TILE) ? j.n - nt * TILE : TILE;
        t.k = j.k;
        t.a = (j.a + mt * j.k) % 65536;
        t.b = (j.b + nt * j.k) % 65536;
        t.c = (j.c + (mt * nt_cnt + nt) * TILE) % 65536;
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic drive_job(input job_t j);
    job_m  = DIM_W'(j.m);
    job_k  = DIM_W'(j.k);
    job_n  = DIM_W'(j.n);
    a_base = ADDR_W'(j.a);
    b_base = ADDR_W'(j.b);
    c_base = ADDR_W'(j.c);
  endtask

  // Called and returns at a negedge. exp_wait < 0 means handshake latency is not checked.
  task automatic run_job(input job_t j, input int rise, input int len, input int exp_wait,
                         input bit overlap, input job_t nx);
    int waited, cyc, idx, exp_done;
    bit got_done;
    build_expected(j);
    rise_cfg = rise;
    len_cfg  = len;
    drive_job(j);
    start_valid = 1'b1;
    waited = 0;
    while (!start_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (exp_wait >= 0) check("hs_latency", waited, exp_wait);
    if (!start_ready) begin
      check("hs_timeout", 0, 1);
      start_valid = 1'b0;
      return;
    end
    @(negedge clk);
    start_valid = 1'b0;
    exp_done = 1 + exp_q.size() * tile_cycles(rise, len);
    cyc = 1;
    idx = 0;
    got_done = 1'b0;
    while (cyc <= 1000 && !got_done) begin
      if (arr_enable) begin
        if (idx < exp_q.size()) begin
          check("tile_m", arr_m, exp_q[idx].m);
          check("tile_n", arr_n, exp_q[idx].n);
          check("tile_k", arr_k, exp_q[idx].k);
          check("a_off", arr_a_off, exp_q[idx].a);
          check("b_off", arr_b_off, exp_q[idx].b);
          check("c_off", arr_c_off, exp_q[idx].c);
        end else begin
          check("extra_launch", idx, exp_q.size());
        end
        if (overlap && idx == 0) begin
          drive_job(nx);
          start_valid = 1'b1;
        end
        idx++;
      end
      if (overlap && start_valid) check("ready_low_in_job", start_ready, 0);
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", cyc, exp_done);
        check("launch_count", idx, exp_q.size());
        check("err", err, (exp_q.size() == 0) ? 1 : 0);
        check("tiles_done", tiles_done, exp_q.size());
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  task automatic run_abort(input job_t j, input int abort_tile);
    int idx, guard, launches, dones;
    build_expected(j);
    rise_cfg = 0;
    len_cfg  = 6;
    drive_job(j);
    start_valid = 1'b1;
    guard = 0;
    while (!start_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    start_valid = 1'b0;
    idx = 0;
    guard = 0;
    while (idx <= abort_tile && guard < 500) begin
      if (arr_enable) idx++;
      if (idx <= abort_tile) begin
        @(negedge clk);
        guard++;
      end
    end
    guard = 0;
    while (!arr_busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_busy_seen", arr_busy, 1);
    @(negedge clk);
    abort = 1'b1;
    check("abort_done_low", done, 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", start_ready, 1);
    check("abort_tiles_done", tiles_done, abort_tile);
    launches = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (arr_enable) launches++;
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_launch", launches, 0);
    check("abort_no_done", dones, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j, nx;
    int rise, len;
    reset_n     = 1'b0;
    start_valid = 1'b0;
    abort       = 1'b0;
    drive_job('{0, 0, 0, 0, 0, 0});
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", start_ready, 1);
    check("rst_enable", arr_enable, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tiles_done", tiles_done, 0);
    check("rst_arr_m", arr_m, 0);
    check("rst_arr_c_off", arr_c_off, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // single full tile
    run_job('{4, 4, 4, 0, 0, 0}, 1, 5, 0, 1'b0, '{0, 0, 0, 0, 0, 0});
    @(negedge clk);

    // 2x2 tiles with edge columns; a second job held on start_valid during tile 0
    nx = '{5, 2, 3, 7, 9, 11};
    run_job('{8, 3, 6, 100, 200, 300}, 0, 2, 0, 1'b1, nx);
    run_job(nx, 1, 3, 1, 1'b0, '{0, 0, 0, 0, 0, 0});
    @(negedge clk);

    // zero dimension
    run_job('{0, 4, 4, 1, 2, 3}, 0, 2, 0, 1'b0, '{0, 0, 0, 0, 0, 0});
    @(negedge clk);

    // busy never rises: each tile times out in ARM
    run_job('{6, 2, 5, 65530, 65535, 65534}, 0, 0, 0, 1'b0, '{0, 0, 0, 0, 0, 0});
    @(negedge clk);

    // abort in RUN of the second tile
    run_abort('{8, 3, 6, 100, 200, 300}, 1);

    // async reset during ARM
    rise_cfg = 1;
    len_cfg  = 4;
    drive_job('{8, 3, 8, 5, 6, 7});
    start_valid = 1'b1;
    begin
      int g;
      g = 0;
      while (!arr_enable && g < 20) begin
        @(negedge clk);
        g++;
      end
    end
    start_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready", start_ready, 1);
    check("arst_enable", arr_enable, 0);
    check("arst_done", done, 0);
    check("arst_tiles_done", tiles_done, 0);
    check("arst_arr_n", arr_n, 0);
    check("arst_arr_a_off", arr_a_off, 0);
    #10 reset_n = 1'b1;
    @(negedge clk);
    check("arst_ready_after", start_ready, 1);
    check("arst_done_after", done, 0);

    // random jobs
    for (int r = 0; r < 30; r++) begin
      j.m = $urandom_range(1, 13);
      j.k = $urandom_range(1, 20);
      j.n = $urandom_range(1, 13);
      case ($urandom_range(0, 9))
        0: j.m = 0;
        1: j.k = 0;
        2: j.n = 0;
        default: ;
      endcase
      j.a = $urandom_range(0, 65535);
      j.b = $urandom_range(0, 65535);
      j.c = $urandom_range(0, 65535);
      rise = $urandom_range(0, 1);
      len = $urandom_range(0, 4);
      run_job(j, rise, len, -1, 1'b0, '{0, 0, 0, 0, 0, 0});
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
